// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, data-memory freeze with timeout, ALU forwarding.
// Define HAZARD_UNIT_STATS_EN to build the saturating load-stall / flush statistics counters.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ifid_rs,
    input  logic [4:0]  ifid_rt,
    input  logic        ifid_uses_rt,
    input  logic [4:0]  idex_rs,
    input  logic [4:0]  idex_rt,
    input  logic        idex_mem_read,
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_write,
    input  logic        branch_taken,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [15:0] load_stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic        mem_timeout_reg;
    logic        load_use;
    logic        freeze_cause;

    assign load_use = idex_mem_read && (idex_rt != 5'd0) &&
                      ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));
    assign freeze_cause = (state_reg == ERROR) || dmem_busy;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (freeze_cause) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Operand 0 compares against idex_rs, operand 1 against idex_rt; EX/MEM beats MEM/WB.
    logic [4:0] fwd_src [2];
    logic [1:0] fwd_sel [2];
    assign fwd_src[0] = idex_rs;
    assign fwd_src[1] = idex_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == fwd_src[gi])) ? 2'b10 :
                (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == fwd_src[gi])) ? 2'b01 :
                                                                                       2'b00;
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            RUN: begin
                if (dmem_busy) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_busy) begin
                    state_next    = RUN;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt_reg == 8'd255) begin
                    state_next = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            ERROR:   state_next = ERROR;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= RUN;
            wait_cnt_reg    <= 8'd0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_timeout_reg <= (state_next == ERROR);
        end
    end

    assign mem_timeout = mem_timeout_reg;

`ifdef HAZARD_UNIT_STATS_EN
    logic        stall_event, flush_event;
    logic [15:0] load_stall_cnt_reg, flush_cnt_reg;

    assign stall_event = !freeze_cause && !branch_taken && load_use;
    assign flush_event = !freeze_cause && branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_cnt_reg <= 16'd0;
            flush_cnt_reg      <= 16'd0;
        end else begin
            if (stall_event && (load_stall_cnt_reg != 16'hFFFF))
                load_stall_cnt_reg <= load_stall_cnt_reg + 16'd1;
            if (flush_event && (flush_cnt_reg != 16'hFFFF))
                flush_cnt_reg <= flush_cnt_reg + 16'd1;
        end
    end

    assign load_stall_cnt = load_stall_cnt_reg;
    assign flush_cnt      = flush_cnt_reg;
`else
    assign load_stall_cnt = 16'd0;
    assign flush_cnt      = 16'd0;
`endif

endmodule
